// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and status constants for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_PLLRST    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int STATUS_W = 4;
  localparam logic [STATUS_W-1:0] STATUS_MAX = 4'd15;

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer for a single asynchronous level or strobe.
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_p;

  always_ff @(posedge clk) begin
    if (reset) sync_p <= '0;
    else       sync_p <= {sync_p[SYNC_STAGES-2:0], d};
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencing and lock qualification on the crystal clock.
// Optional macro PLL_LOCK_SUPERVISOR_AUTO_RETRY_EN: timeouts retry instead of latching fail.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 14318,
  parameter int STABLE_CYCLES = 1432,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic                sys_reset,
  output logic                locked,
  output logic [STATUS_W-1:0] retry_count,
  output logic [STATUS_W-1:0] loss_count,
  output logic                fail
);

  localparam int CNT_MAX_RT = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX    = (CNT_MAX_RT > STABLE_CYCLES) ? CNT_MAX_RT : STABLE_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);

  function automatic logic [STATUS_W-1:0] sat_inc(input logic [STATUS_W-1:0] v);
    return (v == STATUS_MAX) ? v : v + STATUS_W'(1);
  endfunction

  logic                lock_s;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STATUS_W-1:0] retry_q, retry_d;
  logic [STATUS_W-1:0] loss_q, loss_d;
  logic                pll_reset_q, sys_reset_q, locked_q;

  pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as a lock.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = STABLE_LOAD;
        end else if (cnt_q == '0) begin
          retry_d = sat_inc(retry_q);
`ifdef PLL_LOCK_SUPERVISOR_AUTO_RETRY_EN
          state_d = ST_PLLRST;
          cnt_d   = RST_LOAD;
`else
          state_d = ST_FAIL;
          cnt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          loss_d  = sat_inc(loss_q);
          state_d = ST_PLLRST;
          cnt_d   = RST_LOAD;
        end
      end
`ifndef PLL_LOCK_SUPERVISOR_AUTO_RETRY_EN
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
`endif
      default: begin
        state_d = ST_PLLRST;
        cnt_d   = RST_LOAD;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PLLRST;
      cnt_q       <= RST_LOAD;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= (state_d == ST_PLLRST) || (state_d == ST_FAIL);
      sys_reset_q <= (state_d != ST_RUN);
      locked_q    <= (state_d == ST_RUN);
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_AUTO_RETRY_EN
  assign fail = 1'b0;
`else
  logic fail_q;

  always_ff @(posedge clk) begin
    if (reset) fail_q <= 1'b0;
    else       fail_q <= (state_d == ST_FAIL);
  end

  assign fail = fail_q;
`endif

  assign pll_reset   = pll_reset_q;
  assign sys_reset   = sys_reset_q;
  assign locked      = locked_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule
